// File: rtl/pad_reader_pkg.sv
// rtl/pad_reader_pkg.sv - shared constants and FSM encoding for the game pad reader
package pad_reader_pkg;

    localparam int PAD_BITS = 9;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_JUMP  = 4;
    localparam int BTN_PUNCH = 5;
    localparam int BTN_KICK  = 6;
    localparam int BTN_BLOCK = 7;
    localparam int BTN_START = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        SETTLE = 3'd2,
        CLK_HI = 3'd3,
        CLK_LO = 3'd4,
        DONE   = 3'd5
    } pad_state_t;

endpackage

// File: rtl/pad_sync.sv
// rtl/pad_sync.sv - two-flop synchronizer for an asynchronous pad data line
module pad_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_reader.sv
// rtl/pad_reader.sv - polls two serial game pads and presents registered button states
module pad_reader
    import pad_reader_pkg::*;
#(
    parameter int HALF_CYC = 324,
    parameter int POLL_CYC = 1080000,
    parameter int BITS     = PAD_BITS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pad1_data,
    input  logic              pad2_data,
    output logic              pad_latch,
    output logic              pad_clk,
    output logic [2*BITS-1:0] controls,
    output logic              controls_valid,
    output logic              start1_pressed,
    output logic              start2_pressed
);

    localparam int CW = $clog2((POLL_CYC > 2*HALF_CYC) ? POLL_CYC : 2*HALF_CYC);
    localparam int IW = $clog2(BITS);
    localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(2*HALF_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(BITS - 2);

    pad_state_t        state;
    logic [CW-1:0]     poll_cnt;
    logic [CW-1:0]     phase_cnt;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_next;
    logic [BITS-1:0]   sr1;
    logic [BITS-1:0]   sr2;
    logic [1:0]        prev_start;
    logic              sync1;
    logic              sync2;

    // Released pads read as 1, so the synchronizers come out of reset released.
    pad_sync #(.RESET_VAL(1'b1)) u_sync1 (
        .clock (clock),
        .reset (reset),
        .d     (pad1_data),
        .q     (sync1)
    );

    pad_sync #(.RESET_VAL(1'b1)) u_sync2 (
        .clock (clock),
        .reset (reset),
        .d     (pad2_data),
        .q     (sync2)
    );

    assign idx_next = idx + IW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            poll_cnt       <= '0;
            phase_cnt      <= '0;
            idx            <= '0;
            sr1            <= '0;
            sr2            <= '0;
            prev_start     <= '0;
            pad_latch      <= 1'b0;
            pad_clk        <= 1'b0;
            controls       <= '0;
            controls_valid <= 1'b0;
            start1_pressed <= 1'b0;
            start2_pressed <= 1'b0;
        end else begin
            controls_valid <= 1'b0;
            start1_pressed <= 1'b0;
            start2_pressed <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll_cnt == POLL_LAST) begin
                        poll_cnt  <= '0;
                        idx       <= '0;
                        phase_cnt <= '0;
                        pad_latch <= 1'b1;
                        state     <= LATCH;
                    end else begin
                        poll_cnt <= poll_cnt + CW'(1);
                    end
                end
                LATCH: begin
                    if (phase_cnt == LATCH_LAST) begin
                        phase_cnt <= '0;
                        pad_latch <= 1'b0;
                        state     <= SETTLE;
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
                end
                SETTLE: begin
                    if (phase_cnt == HALF_LAST) begin
                        phase_cnt <= '0;
                        sr1[0]    <= sync1;
                        sr2[0]    <= sync2;
                        pad_clk   <= 1'b1;
                        state     <= CLK_HI;
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
                end
                CLK_HI: begin
                    if (phase_cnt == HALF_LAST) begin
                        phase_cnt <= '0;
                        pad_clk   <= 1'b0;
                        state     <= CLK_LO;
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
                end
                CLK_LO: begin
                    if (phase_cnt == HALF_LAST) begin
                        phase_cnt     <= '0;
                        sr1[idx_next] <= sync1;
                        sr2[idx_next] <= sync2;
                        idx           <= idx_next;
                        if (idx == IDX_LAST) begin
                            state <= DONE;
                        end else begin
                            pad_clk <= 1'b1;
                            state   <= CLK_HI;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CW'(1);
                    end
                end
                DONE: begin
                    // Data lines are active-low; invert once here so controls reads 1 = pressed.
                    controls       <= ~{sr2, sr1};
                    controls_valid <= 1'b1;
                    start1_pressed <= ~sr1[BITS-1] & ~prev_start[0];
                    start2_pressed <= ~sr2[BITS-1] & ~prev_start[1];
                    prev_start     <= {~sr2[BITS-1], ~sr1[BITS-1]};
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pad_reader.sv
// tb/tb_pad_reader.sv - scoreboard bench for pad_reader with a serial pad model
module tb_pad_reader;

    localparam int HALF_CYC = 2;
    localparam int POLL_CYC = 20;
    localparam int BITS     = 9;

    typedef struct packed {
        logic [17:0] ctl;
        logic        s1;
        logic        s2;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        pad1_data;
    logic        pad2_data;
    logic        pad_latch;
    logic        pad_clk;
    logic [17:0] controls;
    logic        controls_valid;
    logic        start1_pressed;
    logic        start2_pressed;

    logic [8:0]  btn1;
    logic [8:0]  btn2;
    logic [8:0]  sh1;
    logic [8:0]  sh2;

    int   tests;
    int   fails;
    int   cyc;
    int   n_valid;
    int   latch_rise;
    int   clk_rises;
    logic prev_latch;
    logic prev_clk;
    logic overlap;
    exp_t exp_q[$];

    pad_reader #(
        .HALF_CYC (HALF_CYC),
        .POLL_CYC (POLL_CYC),
        .BITS     (BITS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pad1_data      (pad1_data),
        .pad2_data      (pad2_data),
        .pad_latch      (pad_latch),
        .pad_clk        (pad_clk),
        .controls       (controls),
        .controls_valid (controls_valid),
        .start1_pressed (start1_pressed),
        .start2_pressed (start2_pressed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Pad model: latch loads buttons, each pad_clk rise shifts the next button onto the line.
    always @(posedge pad_latch) begin
        sh1 = btn1;
        sh2 = btn2;
    end
    always @(posedge pad_clk) begin
        sh1 = sh1 >> 1;
        sh2 = sh2 >> 1;
    end
    assign pad1_data = ~sh1[0];
    assign pad2_data = ~sh2[0];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_latch = 1'b0;
            prev_clk   = 1'b0;
        end else begin
            if (pad_latch && pad_clk) overlap = 1'b1;
            if (pad_latch && !prev_latch) begin
                latch_rise = cyc;
                clk_rises  = 0;
            end
            if (!pad_latch && prev_latch) check("latch_width", cyc - latch_rise, 2*HALF_CYC);
            if (pad_clk && !prev_clk) clk_rises++;
            if (controls_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {14'd0, controls}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("controls", {14'd0, controls}, {14'd0, e.ctl});
                    check("start1", {31'd0, start1_pressed}, {31'd0, e.s1});
                    check("start2", {31'd0, start2_pressed}, {31'd0, e.s2});
                    check("latency", cyc - latch_rise, 3*HALF_CYC + 2*(BITS-1)*HALF_CYC + 1);
                    check("clk_rises", clk_rises, BITS - 1);
                end
                n_valid++;
            end else if (start1_pressed || start2_pressed) begin
                check("stray_start", {30'd0, start1_pressed, start2_pressed}, 32'd0);
            end
            prev_latch = pad_latch;
            prev_clk   = pad_clk;
        end
    end

    task automatic wait_latch(input string name, input int want);
        int k;
        k = 0;
        while (!pad_latch && k < 200) begin
            @(posedge clock);
            #1;
            k++;
        end
        check(name, k, want);
    endtask

    task automatic do_read(input logic [8:0] b1, input logic [8:0] b2,
                           input logic [17:0] ctl, input logic s1, input logic s2);
        exp_t e;
        int   target;
        int   k;
        btn1 = b1;
        btn2 = b2;
        e.ctl = ctl;
        e.s1  = s1;
        e.s2  = s2;
        exp_q.push_back(e);
        target = n_valid + 1;
        k = 0;
        while (n_valid < target && k < 400) begin
            @(negedge clock);
            k++;
        end
        if (n_valid < target) begin
            tests++;
            fails++;
            $display("FAIL read_timeout: got %0d valids expected %0d", n_valid, target);
        end
    endtask

    initial begin
        int k;
        tests = 0; fails = 0; cyc = 0; n_valid = 0;
        latch_rise = 0; clk_rises = 0; overlap = 1'b0;
        prev_latch = 1'b0; prev_clk = 1'b0;
        btn1 = '0; btn2 = '0; sh1 = '0; sh2 = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_state",
              {8'd0, controls, pad_latch, pad_clk, controls_valid, start1_pressed, start2_pressed},
              32'd0);
        reset = 1'b0;
        wait_latch("first_latch", POLL_CYC);

        do_read(9'h000, 9'h000, 18'h00000, 1'b0, 1'b0);
        do_read(9'h0A5, 9'h000, 18'h000A5, 1'b0, 1'b0);
        do_read(9'h100, 9'h000, 18'h00100, 1'b1, 1'b0);
        do_read(9'h100, 9'h000, 18'h00100, 1'b0, 1'b0);
        do_read(9'h000, 9'h000, 18'h00000, 1'b0, 1'b0);
        do_read(9'h1FF, 9'h1FF, 18'h3FFFF, 1'b1, 1'b1);
        do_read(9'h000, 9'h0C3, 18'h18600, 1'b0, 1'b0);

        // Abort a read while pad_clk is high on the fourth shift.
        btn1 = 9'h1FF;
        btn2 = 9'h000;
        k = 0;
        while (!pad_latch && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        k = 0;
        while (clk_rises < 4 && k < 200) begin
            @(negedge clock);
            #1;
            k++;
        end
        check("pre_abort_clk", {31'd0, pad_clk}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_outputs",
              {11'd0, controls, pad_latch, pad_clk, controls_valid},
              32'd0);
        @(negedge clock);
        reset = 1'b0;
        wait_latch("post_abort_latch", POLL_CYC);
        do_read(9'h1FF, 9'h000, 18'h001FF, 1'b1, 1'b0);

        check("queue_empty", exp_q.size(), 0);
        check("latch_clk_overlap", {31'd0, overlap}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
